// File: rtl/multdiv_if.sv
// Handshake and data bundle for the multicycle multiply/divide unit.
// The control unit drives the master side; multdiv_unit is the slave.
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/multdiv_unit.sv
// Multicycle signed/unsigned multiply and restoring divide owning HI/LO.
// One result bit per cycle on magnitudes, sign fixed up in a final cycle.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    multdiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dz_q, dz_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               divz_q, divz_d;

    logic               in_sgn, a_neg, b_neg, in_div, in_dz;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand conditioning: magnitudes and sign bookkeeping at accept time
    always_comb begin
        in_sgn = ~bus.op[1];
        in_div = bus.op[0];
        a_neg  = in_sgn & bus.a[WIDTH-1];
        b_neg  = in_sgn & bus.b[WIDTH-1];
        a_abs  = a_neg ? -bus.a : bus.a;
        b_abs  = b_neg ? -bus.b : bus.b;
        in_dz  = in_div && (bus.b == '0);
    end

    // Per-cycle step: shift-add for multiply, restoring step for divide
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        div_next = div_diff[WIDTH]
                 ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                          : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = in_dz ? FIX : RUN;
            RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d   = op_q;
        acc_d  = acc_q;
        opb_d  = opb_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        done_d = 1'b0;
        divz_d = divz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    op_d   = bus.op;
                    acc_d  = {{WIDTH{1'b0}}, in_div ? a_abs : b_abs};
                    opb_d  = in_div ? b_abs : a_abs;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    dz_d   = in_dz;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    divz_d = 1'b0;
                end
            end
            RUN: begin
                acc_d = op_q[0] ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
            end
            FIX: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                if (dz_q) begin
                    divz_d = 1'b1;
                end else if (op_q[0]) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: ;
        endcase
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = divz_q;
endmodule
